// File: rtl/shared_ripple_adder_arbiter.sv
// Round-robin shared ripple-carry adder: requesters stream multi-word additions
// LSW first, with the inter-word carry held between words of a locked frame.
module shared_ripple_adder_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int INPUTS     = 2,
    localparam int ID_WIDTH  = (INPUTS <= 2) ? 1 : $clog2(INPUTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS*DATA_WIDTH-1:0] in_a,
    input  logic [INPUTS*DATA_WIDTH-1:0] in_b,
    input  logic [INPUTS-1:0]            in_ci,
    input  logic [INPUTS-1:0]            in_last,
    input  logic [INPUTS-1:0]            in_vld,
    output logic [INPUTS-1:0]            in_rd,
    output logic [DATA_WIDTH-1:0]        out_s,
    output logic                         out_co,
    output logic                         out_last,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic                         out_vld,
    input  logic                         out_rd
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            r_state;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [ID_WIDTH-1:0]   r_grant;
    logic                  r_carry;

    logic                  w_free;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_pick;
    int unsigned           w_best;
    int unsigned           w_dist;
    logic [ID_WIDTH-1:0]   w_sel;
    logic                  w_sel_vld;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic                  w_ci;
    logic                  w_last;
    logic [DATA_WIDTH:0]   w_sum;

    assign w_free = !out_vld || out_rd;

    // Priority is the distance from r_ptr+1 (mod INPUTS); the closest valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_best  = INPUTS;
        w_dist  = 0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
            w_dist = (i + INPUTS - 32'(r_ptr) - 1) % INPUTS;
            if (in_vld[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_found = 1'b1;
                w_pick  = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        if (r_state == ST_LOCKED) begin
            w_sel     = r_grant;
            w_sel_vld = 1'b0;
        end else begin
            w_sel     = w_pick;
            w_sel_vld = w_found;
        end
        w_a    = '0;
        w_b    = '0;
        w_ci   = 1'b0;
        w_last = 1'b0;
        in_rd  = '0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
            if (ID_WIDTH'(i) == w_sel) begin
                w_a    = in_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_b    = in_b[i*DATA_WIDTH +: DATA_WIDTH];
                w_ci   = in_ci[i];
                w_last = in_last[i];
                if (r_state == ST_LOCKED) begin
                    w_sel_vld = in_vld[i];
                    in_rd[i]  = w_free;
                end else begin
                    in_rd[i]  = w_free && w_found;
                end
            end
        end
        if (r_state == ST_LOCKED) begin
            w_ci = r_carry;
        end
        w_xfer = w_free && w_sel_vld;
        w_sum  = {1'b0, w_a} + {1'b0, w_b} + {{DATA_WIDTH{1'b0}}, w_ci};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= ID_WIDTH'(INPUTS - 1);
            r_grant  <= '0;
            r_carry  <= 1'b0;
            out_vld  <= 1'b0;
            out_s    <= '0;
            out_co   <= 1'b0;
            out_last <= 1'b0;
            out_id   <= '0;
        end else begin
            if (w_free) begin
                out_vld <= w_xfer;
            end
            if (w_xfer) begin
                out_s    <= w_sum[DATA_WIDTH-1:0];
                out_co   <= w_sum[DATA_WIDTH];
                out_last <= w_last;
                out_id   <= w_sel;
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_ptr   <= w_sel;
                    r_carry <= 1'b0;
                end else begin
                    r_state <= ST_LOCKED;
                    r_grant <= w_sel;
                    r_carry <= w_sum[DATA_WIDTH];
                end
            end
        end
    end

endmodule
